if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register in the 16-bit pipelined CPU. It owns the PC and fetches 16-bit instructions from instruction memory over a req/ack handshake. It presents each fetched instruction and its PC+2 to IF/ID, and honours the data-hazard stall (DHZ_i) and the control-hazard redirect (CHZ_i) from the hazard unit. When no valid instruction is available, it drives the NOP/bubble encoding.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'hC000, bubble encoding driven on Instruction_o when fetch_valid_o=0.
PC_STEP, 2, PC increment per instruction (byte-addressed, 16-bit instructions).

Ports:
clk_i  input  1  clock; all state updates on posedge.
rst_i  input  1  asynchronous, active-high reset.
DHZ_i  input  1  data-hazard stall; 1 = downstream does not consume this cycle.
CHZ_i  input  1  control hazard/redirect; 1 = flush and refetch from branch_target_i.
branch_target_i  input  16  redirect PC; bit0 forced to 0 internally.
imem_req_o  output  1  fetch request to instruction memory.
imem_addr_o  output  16  fetch address (current PC).
imem_ack_i  input  1  memory returns data this cycle; meaningful only while imem_req_o=1.
imem_rdata_i  input  16  instruction word, sampled only on req&ack.
Instruction_o  output  16  instruction to IF/ID (NOP_INSTR when not valid).
PCadder1_sum_o  output  16  PC+PC_STEP of the current PC, to IF/ID.
fetch_valid_o  output  1  Instruction_o holds a real fetched instruction.

Behaviour:
- Registers: pc[15:0], ibuf[15:0], state in {IDLE, FETCH, VALID}.
- Reset (async, rst_i=1, effective mid-operation too):
  - pc=RESET_PC, ibuf=NOP_INSTR, state=IDLE.
  - Outputs: imem_req_o=0, fetch_valid_o=0, Instruction_o=NOP_INSTR, PCadder1_sum_o=RESET_PC+PC_STEP.
- IDLE: no request. Next cycle goes to FETCH unconditionally, unless CHZ_i=1, in which case pc<=target and state goes to FETCH.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc; Instruction_o=NOP_INSTR, fetch_valid_o=0.
  - req stays asserted until ack; any number of wait cycles is allowed.
  - On ack with CHZ_i=0: ibuf<=imem_rdata_i, state goes to VALID, pc unchanged.
  - On ack with CHZ_i=1: data discarded, pc<=branch_target_i&16'hFFFE, stay in FETCH. The new address appears on imem_addr_o next cycle.
  - No ack with CHZ_i=1: pc<=target, stay in FETCH. The in-flight request is abandoned; memory must accept an address change while req is high.
- VALID:
  - imem_req_o=0, Instruction_o=ibuf, fetch_valid_o=1.
  - CHZ_i=1 (highest priority): ibuf<=NOP_INSTR, pc<=target, state goes to FETCH.
  - Else DHZ_i=0: instruction is consumed by IF/ID at this edge; pc<=pc+PC_STEP, state goes to FETCH.
  - Else DHZ_i=1: hold all state; outputs stable for as many cycles as the stall lasts.
- PCadder1_sum_o = pc+PC_STEP combinationally in all states.
- Arithmetic and ordering:
  - All PC arithmetic is modulo 2^16: 16'hFFFE+2 = 16'h0000.
  - Latency: an ack at edge N gives fetch_valid_o=1 after edge N. Throughput is at most 1 instruction per 2 cycles (zero-wait memory).
  - CHZ_i and DHZ_i together: CHZ_i wins.
  - imem_ack_i while imem_req_o=0: ignored.
  - A fetched instruction is never delivered twice and never dropped except by CHZ_i.

Test Plan:
1. Assert rst_i mid-FETCH with pc=16'h0010 -> outputs immediately req=0, valid=0, Instruction_o=16'hC000, PCadder1_sum_o=16'h0002. After release: IDLE, then req with addr=16'h0000.
2. Zero-wait memory returns 16'h1234 at 0x0000 and 16'h5678 at 0x0002, DHZ_i=0 -> valid pulses with 16'h1234/PC+2=16'h0002, then 16'h5678/16'h0004. Addresses step 0,2,4.
3. In VALID with 16'h1234, hold DHZ_i=1 for 3 cycles -> Instruction_o=16'h1234, valid=1, req=0, pc unchanged for all 3 cycles. Dropping DHZ_i resumes with addr=16'h0002.
4. Memory ack delayed 4 cycles -> req held high, addr stable, Instruction_o=16'hC000 throughout. Data captured only on the ack cycle.
5. CHZ_i=1 with branch_target_i=16'h0041 while VALID and DHZ_i=1 -> next cycle FETCH, addr=16'h0040, valid=0, Instruction_o=16'hC000. Repeat with CHZ_i coincident with ack -> ack data discarded.
6. Start pc at 16'hFFFE, consume one instruction -> PCadder1_sum_o=16'h0000, next imem_addr_o=16'h0000.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches 16-bit words over a req/ack
// handshake and presents them (with PC+2) to the IF/ID register.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hC000,
  parameter logic [15:0] PC_STEP   = 16'd2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        DHZ_i,
  input  logic        CHZ_i,
  input  logic [15:0] branch_target_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] Instruction_o,
  output logic [15:0] PCadder1_sum_o,
  output logic        fetch_valid_o
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ibuf;
  logic        req_q;
  logic        vld_q;
  logic [15:0] tgt;

  assign tgt = {branch_target_i[15:1], 1'b0};

  // ibuf doubles as the registered instruction output: it holds NOP_INSTR
  // whenever the stage is not VALID, so no output mux is needed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ibuf  <= NOP_INSTR;
      req_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
          if (CHZ_i) pc <= tgt;
        end
        FETCH: begin
          // A redirect abandons the in-flight request, acked or not.
          if (CHZ_i) begin
            pc <= tgt;
          end else if (imem_ack_i) begin
            ibuf  <= imem_rdata_i;
            state <= VALID;
            req_q <= 1'b0;
            vld_q <= 1'b1;
          end
        end
        VALID: begin
          if (CHZ_i) begin
            ibuf  <= NOP_INSTR;
            pc    <= tgt;
            state <= FETCH;
            req_q <= 1'b1;
            vld_q <= 1'b0;
          end else if (!DHZ_i) begin
            ibuf  <= NOP_INSTR;
            pc    <= pc + PC_STEP;
            state <= FETCH;
            req_q <= 1'b1;
            vld_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ibuf  <= NOP_INSTR;
          req_q <= 1'b0;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o     = req_q;
  assign imem_addr_o    = pc;
  assign Instruction_o  = ibuf;
  assign fetch_valid_o  = vld_q;
  assign PCadder1_sum_o = pc + PC_STEP;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: hand-computed expectations for reset,
// streaming, stall, slow memory, redirect and PC wrap.
module tb_if_fetch_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        DHZ_i, CHZ_i, imem_ack_i;
  logic [15:0] branch_target_i, imem_rdata_i;
  logic        imem_req_o, fetch_valid_o;
  logic [15:0] imem_addr_o, Instruction_o, PCadder1_sum_o;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .DHZ_i(DHZ_i), .CHZ_i(CHZ_i),
    .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .Instruction_o(Instruction_o), .PCadder1_sum_o(PCadder1_sum_o),
    .fetch_valid_o(fetch_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full output snapshot check.
  task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                         input logic vld, input logic [15:0] ins, input logic [15:0] sum);
    chk({tag, ".req"},   {15'd0, imem_req_o},    {15'd0, req});
    chk({tag, ".addr"},  imem_addr_o,            addr);
    chk({tag, ".valid"}, {15'd0, fetch_valid_o}, {15'd0, vld});
    chk({tag, ".instr"}, Instruction_o,          ins);
    chk({tag, ".sum"},   PCadder1_sum_o,         sum);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; DHZ_i = 1'b0; CHZ_i = 1'b0; imem_ack_i = 1'b0;
    branch_target_i = 16'h0000; imem_rdata_i = 16'h0000;
    tick();
    chk_all("reset", 1'b0, 16'h0000, 1'b0, 16'hC000, 16'h0002);

    // Ack while idle must be ignored; IDLE always proceeds to FETCH.
    rst_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 16'h5555;
    tick();
    chk_all("idle_ack", 1'b1, 16'h0000, 1'b0, 16'hC000, 16'h0002);

    // Zero-wait fetch of 0x1234, then stall three cycles.
    imem_rdata_i = 16'h1234;
    tick();
    chk_all("v1234", 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0002);
    imem_ack_i = 1'b0; DHZ_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("stall", 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0002);
    end
    DHZ_i = 1'b0;
    tick();
    chk_all("f0002", 1'b1, 16'h0002, 1'b0, 16'hC000, 16'h0004);
    imem_ack_i = 1'b1; imem_rdata_i = 16'h5678;
    tick();
    chk_all("v5678", 1'b0, 16'h0002, 1'b1, 16'h5678, 16'h0004);
    imem_ack_i = 1'b0;
    tick();
    chk_all("f0004", 1'b1, 16'h0004, 1'b0, 16'hC000, 16'h0006);

    // Slow memory: four wait cycles with garbage on the data bus.
    imem_rdata_i = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("wait", 1'b1, 16'h0004, 1'b0, 16'hC000, 16'h0006);
    end
    imem_ack_i = 1'b1; imem_rdata_i = 16'h9ABC;
    tick();
    chk_all("v9abc", 1'b0, 16'h0004, 1'b1, 16'h9ABC, 16'h0006);

    // Redirect from VALID during a stall: CHZ wins, bit0 cleared.
    imem_ack_i = 1'b0; DHZ_i = 1'b1; CHZ_i = 1'b1; branch_target_i = 16'h0041;
    tick();
    chk_all("chz_valid", 1'b1, 16'h0040, 1'b0, 16'hC000, 16'h0042);

    // Redirect coincident with ack: data discarded, stay fetching.
    DHZ_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 16'hBEEF; branch_target_i = 16'h0081;
    tick();
    chk_all("chz_ack", 1'b1, 16'h0080, 1'b0, 16'hC000, 16'h0082);

    // Redirect without ack to 0xFFFE, then wrap on consume.
    imem_ack_i = 1'b0; branch_target_i = 16'hFFFF;
    tick();
    chk_all("chz_wrap", 1'b1, 16'hFFFE, 1'b0, 16'hC000, 16'h0000);
    CHZ_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 16'h1111;
    tick();
    chk_all("v1111", 1'b0, 16'hFFFE, 1'b1, 16'h1111, 16'h0000);
    imem_ack_i = 1'b0;
    tick();
    chk_all("wrap", 1'b1, 16'h0000, 1'b0, 16'hC000, 16'h0002);

    // Async reset mid-FETCH at pc=0x0010.
    CHZ_i = 1'b1; branch_target_i = 16'h0010;
    tick();
    chk_all("f0010", 1'b1, 16'h0010, 1'b0, 16'hC000, 16'h0012);
    CHZ_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 16'h0000, 1'b0, 16'hC000, 16'h0002);
    tick();
    rst_i = 1'b0;
    tick();
    chk_all("post_rst", 1'b1, 16'h0000, 1'b0, 16'hC000, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
